console_port_responder: RTL and testbench

Z80 I/O-space responder for the S100 console: the peripheral end of the port chip-select scheme. It answers CPU IN/OUT cycles at a status port and a data port. Received console bytes are buffered in a small RX FIFO. Transmitted bytes go to a single TX holding register with a valid/ready handshake toward the console side. Its read-data output and select feed the CPU data-in multiplexer.

---
 rtl/console_port_responder.sv | 124 ++++++++++++
 tb/tb_console_port_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/console_port_responder.sv
// Z80 I/O responder for the S100 console: status/data ports, RX FIFO, TX holding register.
// Latency: reads are combinational (no wait states); FIFO pop, TX load and flag updates land one clock after the cycle edge.
// Backpressure: RX bytes arriving at a full FIFO are dropped (rx_overrun); OUTs while TX is full are dropped (tx_drop).
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   address, ioread, iowrite  Z80 I/O cycle (levels, may span several clocks)
//   cpu_dout                  CPU write data, valid while iowrite is high
//   port_din, port_din_sel    read data and select toward the CPU data-in mux
//   rx_strobe, rx_data        one-clock console byte arrival
//   tx_valid, tx_data, tx_ready  TX holding register handshake toward the console
module console_port_responder #(
  parameter int         DEPTH       = 4,
  parameter logic [7:0] STATUS_PORT = 8'h00,
  parameter logic [7:0] DATA_PORT   = 8'h01
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] address,
  input  logic       iowrite,
  input  logic       ioread,
  input  logic [7:0] cpu_dout,
  output logic [7:0] port_din,
  output logic       port_din_sel,
  input  logic       rx_strobe,
  input  logic [7:0] rx_data,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic             ioread_d;
  logic             iowrite_d;
  logic [7:0]       rd_addr;
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             rx_overrun;
  logic             tx_drop;

  logic in_start, in_end, out_start;
  logic rx_empty, rx_full;
  logic pop, push, overrun_set, flags_clr, tx_load, drop_set;

  // Edges are taken from registered copies so a multi-clock IN/OUT acts once.
  assign in_start  = ioread & ~ioread_d;
  assign in_end    = ~ioread & ioread_d;
  assign out_start = iowrite & ~iowrite_d;

  assign rx_empty = (count == '0);
  assign rx_full  = (count == CNT_W'(DEPTH));

  // IN-end actions use the address captured at IN start, since the bus
  // address may already have moved on when ioread drops.
  assign pop       = in_end & (rd_addr == DATA_PORT) & ~rx_empty;
  assign flags_clr = in_end & (rd_addr == STATUS_PORT);

  // A pop in the same clock frees the slot, so a full FIFO still accepts.
  assign push        = rx_strobe & (~rx_full | pop);
  assign overrun_set = rx_strobe & rx_full & ~pop;

  // TX occupancy is judged before any same-clock accept: the write is dropped.
  assign tx_load  = out_start & (address == DATA_PORT) & ~tx_valid;
  assign drop_set = out_start & (address == DATA_PORT) & tx_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      ioread_d   <= 1'b0;
      iowrite_d  <= 1'b0;
      rd_addr    <= 8'h00;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rx_overrun <= 1'b0;
      tx_drop    <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
    end else begin
      ioread_d  <= ioread;
      iowrite_d <= iowrite;
      if (in_start) rd_addr <= address;

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);

      // A dropping event in the clearing clock wins, so set comes last.
      if (flags_clr)   rx_overrun <= 1'b0;
      if (overrun_set) rx_overrun <= 1'b1;
      if (flags_clr)   tx_drop    <= 1'b0;
      if (drop_set)    tx_drop    <= 1'b1;

      if (tx_valid && tx_ready) tx_valid <= 1'b0;
      if (tx_load) begin
        tx_valid <= 1'b1;
        tx_data  <= cpu_dout;
      end
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  always_comb begin
    port_din     = 8'h00;
    port_din_sel = 1'b0;
    if (!reset && ioread) begin
      if (address == STATUS_PORT) begin
        port_din_sel = 1'b1;
        port_din     = {4'b0000, tx_drop, rx_overrun, ~tx_valid, ~rx_empty};
      end else if (address == DATA_PORT) begin
        port_din_sel = 1'b1;
        port_din     = rx_empty ? 8'h00 : mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_console_port_responder.sv
// Bench for console_port_responder: directed IN/OUT/RX vectors with a
// scoreboard of expected read bytes and expected accepted TX bytes.
module tb_console_port_responder;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] address;
  logic       iowrite;
  logic       ioread;
  logic [7:0] cpu_dout;
  logic [7:0] port_din;
  logic       port_din_sel;
  logic       rx_strobe;
  logic [7:0] rx_data;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  console_port_responder dut (
    .clock(clock), .reset(reset), .address(address), .iowrite(iowrite),
    .ioread(ioread), .cpu_dout(cpu_dout), .port_din(port_din),
    .port_din_sel(port_din_sel), .rx_strobe(rx_strobe), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
  );

  always #5 clock = ~clock;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] rd_q[$];
  logic [7:0] tx_q[$];

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic io_rd(input logic [7:0] a, input int len, input logic [7:0] exp);
    rd_q.push_back(exp);
    address = a;
    ioread  = 1'b1;
    tick(len);
    ioread  = 1'b0;
    tick(1);
  endtask

  task automatic io_wr(input logic [7:0] a, input logic [7:0] d, input int len);
    address  = a;
    cpu_dout = d;
    iowrite  = 1'b1;
    tick(len);
    iowrite  = 1'b0;
    tick(1);
  endtask

  task automatic rx(input logic [7:0] d);
    rx_data   = d;
    rx_strobe = 1'b1;
    tick(1);
    rx_strobe = 1'b0;
  endtask

  // Monitor state: one expected byte per IN cycle, checked on every clock of it.
  logic       in_prog = 1'b0;
  logic       in_bad  = 1'b0;
  logic [7:0] cur_exp = 8'h00;

  initial begin
    reset = 1'b1; address = 8'h00; iowrite = 1'b0; ioread = 1'b0;
    cpu_dout = 8'h00; rx_strobe = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    fork
      forever begin
        @(negedge clock);
        if (port_din_sel) begin
          if (!in_prog) begin
            in_prog = 1'b1;
            in_bad  = 1'b0;
            if (rd_q.size() == 0) begin
              n_vec++; n_err++; in_bad = 1'b1;
              $display("FAIL unexpected_read: got %h, expected no read", port_din);
            end else begin
              cur_exp = rd_q.pop_front();
              check("read_data", port_din, cur_exp);
              in_bad = (port_din !== cur_exp);
            end
          end else if (!in_bad && port_din !== cur_exp) begin
            in_bad = 1'b1;
            check("read_stable", port_din, cur_exp);
          end
        end else begin
          in_prog = 1'b0;
        end
        if (tx_valid && tx_ready) begin
          if (tx_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_tx_accept: got %h, expected none", tx_data);
          end else begin
            check("tx_accept", tx_data, tx_q.pop_front());
          end
        end
      end
      begin
        tick(2);
        check("rst_port_din", port_din, 8'h00);
        check("rst_sel", {7'b0, port_din_sel}, 8'h00);
        check("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
        check("rst_tx_data", tx_data, 8'h00);
        reset = 1'b0;
        tick(1);

        // Idle status, then FIFO order with long and short IN cycles.
        io_rd(8'h00, 3, 8'h02);
        rx(8'h41); rx(8'h42);
        io_rd(8'h01, 4, 8'h41);
        io_rd(8'h01, 2, 8'h42);
        io_rd(8'h01, 2, 8'h00);
        io_rd(8'h00, 1, 8'h02);

        // Unmapped address is not selected.
        address = 8'h05; ioread = 1'b1; tick(1);
        check("other_sel", {7'b0, port_din_sel}, 8'h00);
        check("other_din", port_din, 8'h00);
        ioread = 1'b0; tick(1);

        // Overrun: 5 pushes into DEPTH=4, sticky until a status read.
        for (int i = 0; i < 5; i++) rx(8'h10 + 8'(i));
        io_rd(8'h00, 2, 8'h07);
        io_rd(8'h00, 2, 8'h03);

        // Push while full in the same clock as a pop: accepted, no overrun.
        rd_q.push_back(8'h10);
        address = 8'h01; ioread = 1'b1; tick(2);
        ioread = 1'b0; rx_data = 8'h20; rx_strobe = 1'b1; tick(1);
        rx_strobe = 1'b0; tick(1);
        io_rd(8'h00, 1, 8'h03);
        io_rd(8'h01, 1, 8'h11);
        io_rd(8'h01, 1, 8'h12);
        io_rd(8'h01, 1, 8'h13);
        io_rd(8'h01, 1, 8'h20);
        io_rd(8'h01, 1, 8'h00);
        io_rd(8'h00, 1, 8'h02);

        // TX load, drop when full, status-port OUT ignored, accept.
        io_wr(8'h01, 8'h55, 3);
        check("tx_valid_load", {7'b0, tx_valid}, 8'h01);
        check("tx_data_load", tx_data, 8'h55);
        io_wr(8'h01, 8'hAA, 2);
        io_rd(8'h00, 1, 8'h08);
        io_rd(8'h00, 1, 8'h00);
        io_wr(8'h00, 8'h77, 2);
        check("tx_data_hold", tx_data, 8'h55);
        tx_q.push_back(8'h55);
        tx_ready = 1'b1; tick(1); tx_ready = 1'b0;
        check("tx_valid_clr", {7'b0, tx_valid}, 8'h00);

        // Accept and OUT start in the same clock: the write is dropped.
        io_wr(8'h01, 8'h66, 1);
        tx_q.push_back(8'h66);
        address = 8'h01; cpu_dout = 8'h99; iowrite = 1'b1; tx_ready = 1'b1;
        tick(1);
        tx_ready = 1'b0; tick(2); iowrite = 1'b0; tick(1);
        check("tx_same_clk", {7'b0, tx_valid}, 8'h00);
        io_rd(8'h00, 1, 8'h0A);

        // A long OUT acts once: no drop flagged.
        io_wr(8'h01, 8'h31, 4);
        io_rd(8'h00, 1, 8'h00);
        tx_q.push_back(8'h31);
        tx_ready = 1'b1; tick(1); tx_ready = 1'b0;

        // Reset in the middle of a status read with data buffered.
        rx(8'h51); rx(8'h52);
        io_wr(8'h01, 8'h77, 2);
        rd_q.push_back(8'h01);
        address = 8'h00; ioread = 1'b1; tick(2);
        reset = 1'b1; tick(1);
        check("midrst_din", port_din, 8'h00);
        check("midrst_sel", {7'b0, port_din_sel}, 8'h00);
        check("midrst_tx_valid", {7'b0, tx_valid}, 8'h00);
        check("midrst_tx_data", tx_data, 8'h00);
        rd_q.push_back(8'h02);
        reset = 1'b0; tick(2);
        ioread = 1'b0; tick(1);
        io_rd(8'h01, 1, 8'h00);
        tick(2);
      end
    join_any
    check("reads_left", 8'(rd_q.size()), 8'h00);
    check("tx_left", 8'(tx_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
